// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl - multi-cycle control FSM for the FPGA MIPS core.
//
// Steps one instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
// It drives the datapath write enables, the mux selects, the ALU op and the
// immediate-extender mode. The data-memory access is a req/ack handshake.
// A DM that never answers is abandoned after DM_TIMEOUT MEMORY cycles. This
// raises the sticky err_timeout flag and does not write the GRF. Retired
// instructions are counted in icount.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   opcode      in   IR[31:26], valid from DECODE onward
//   funct       in   IR[5:0]
//   zero        in   ALU equal flag, valid in EXECUTE
//   dm_ack      in   one-cycle DM completion pulse
//   pcwr        out  PC write enable
//   irwr        out  IR write enable
//   regwr       out  GRF write enable
//   dm_req      out  DM request, held until dm_ack or timeout
//   dm_we       out  DM write strobe, qualified by dm_req
//   extctr      out  0 zero-extend imm16, 1 sign-extend imm16
//   alubsel     out  ALU B operand: 0 GRF[rt], 1 extender
//   aluop       out  0 add, 1 sub, 2 or, 3 lui
//   npcsel      out  0 pc+4, 1 branch, 2 jump target, 3 GRF[rs]
//   regdst      out  0 rt, 1 rd, 2 $31
//   wdsel       out  0 ALU, 1 DM data, 2 pc+4
//   state       out  current FSM state (debug)
//   illegal     out  one-cycle pulse on an unsupported instruction
//   err_timeout out  sticky DM timeout flag
//   icount      out  retired instruction count, wraps
// ---------------------------------------------------------------------------
module mc_ctrl #(
  parameter int CNT_W      = 32,
  parameter int DM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             dm_ack,
  output logic             pcwr,
  output logic             irwr,
  output logic             regwr,
  output logic             dm_req,
  output logic             dm_we,
  output logic             extctr,
  output logic             alubsel,
  output logic [2:0]       aluop,
  output logic [1:0]       npcsel,
  output logic [1:0]       regdst,
  output logic [1:0]       wdsel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] icount
);

  localparam int WAIT_W = $clog2(DM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ,
    I_J, I_JR, I_JAL, I_ILL
  } ins_t;

  state_t            state_q, state_d;
  ins_t              ins_q, ins_d, dec_ins;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  icount_q, icount_d;
  logic              retire, timeout;

  // Classify the live IR fields. The class is latched in DECODE, so
  // later states do not depend on opcode/funct staying stable.
  always_comb begin
    dec_ins = I_ILL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   dec_ins = I_ADDU;
          6'h23:   dec_ins = I_SUBU;
          6'h08:   dec_ins = I_JR;
          default: dec_ins = I_ILL;
        endcase
      end
      6'h0D:   dec_ins = I_ORI;
      6'h0F:   dec_ins = I_LUI;
      6'h23:   dec_ins = I_LW;
      6'h2B:   dec_ins = I_SW;
      6'h04:   dec_ins = I_BEQ;
      6'h02:   dec_ins = I_J;
      6'h03:   dec_ins = I_JAL;
      default: dec_ins = I_ILL;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ins_d    = ins_q;
    wait_d   = '0;
    err_d    = err_q;
    icount_d = icount_q;
    retire   = 1'b0;
    timeout  = 1'b0;
    pcwr     = 1'b0;
    irwr     = 1'b0;
    regwr    = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    extctr   = 1'b0;
    alubsel  = 1'b0;
    aluop    = 3'd0;
    npcsel   = 2'd0;
    regdst   = 2'd0;
    wdsel    = 2'd0;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        irwr    = 1'b1;
        pcwr    = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        ins_d   = dec_ins;
        state_d = S_FETCH;
        case (dec_ins)
          I_J: begin
            pcwr   = 1'b1;
            npcsel = 2'd2;
            retire = 1'b1;
          end
          I_JR: begin
            pcwr   = 1'b1;
            npcsel = 2'd3;
            retire = 1'b1;
          end
          I_JAL: begin
            pcwr   = 1'b1;
            npcsel = 2'd2;
            regwr  = 1'b1;
            regdst = 2'd2;
            wdsel  = 2'd2;
            retire = 1'b1;
          end
          I_ILL:   illegal = 1'b1;
          default: state_d = S_EXECUTE;
        endcase
      end

      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        case (ins_q)
          I_ADDU: aluop = 3'd0;
          I_SUBU: aluop = 3'd1;
          I_ORI: begin
            aluop   = 3'd2;
            alubsel = 1'b1;
          end
          I_LUI: begin
            aluop   = 3'd3;
            alubsel = 1'b1;
          end
          I_LW, I_SW: begin
            alubsel = 1'b1;
            extctr  = 1'b1;
            state_d = S_MEMORY;
          end
          I_BEQ: begin
            aluop   = 3'd1;
            extctr  = 1'b1;
            pcwr    = zero;
            npcsel  = 2'd1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMORY: begin
        dm_req = 1'b1;
        dm_we  = (ins_q == I_SW);
        if (dm_ack) begin
          if (ins_q == I_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_W'(DM_TIMEOUT - 1)) begin
          // This is the DM_TIMEOUT-th cycle without an ack: abandon the access.
          timeout = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WRITEBACK: begin
        regwr   = 1'b1;
        regdst  = (ins_q == I_ADDU || ins_q == I_SUBU) ? 2'd1 : 2'd0;
        wdsel   = (ins_q == I_LW) ? 2'd1 : 2'd0;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    if (retire)  icount_d = icount_q + CNT_W'(1);
    if (timeout) err_d    = 1'b1;

    // Hold every strobe and select low while reset is asserted. This also
    // covers the cycle before the first reset edge.
    if (!reset) begin
      pcwr    = 1'b0;
      irwr    = 1'b0;
      regwr   = 1'b0;
      dm_req  = 1'b0;
      dm_we   = 1'b0;
      extctr  = 1'b0;
      alubsel = 1'b0;
      aluop   = 3'd0;
      npcsel  = 2'd0;
      regdst  = 2'd0;
      wdsel   = 2'd0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      ins_q    <= I_ILL;
      wait_q   <= '0;
      err_q    <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      ins_q    <= ins_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      icount_q <= icount_d;
    end
  end

  assign state       = state_q;
  assign err_timeout = err_q;
  assign icount      = icount_q;

endmodule
